deshifr_walk: RTL and testbench

Rate-limited binary-to-one-hot decoder, the receive-side counterpart of the one-hot-to-index encoder on the lab board. A button press captures an 8-bit position code. The registered one-hot output then walks one bit per prescaler tick from its current position to the captured position, so the move is visible on the LEDs. Sits between the switch/button inputs and the 16-LED bank.

---
 rtl/deshifr_walk.sv | 141 ++++++++++++++
 tb/tb_deshifr_walk.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/deshifr_walk.sv
// deshifr_walk: rate-limited binary-to-one-hot decoder; a button press captures a
//   target code and the one-hot output walks one position per prescaler tick.
// Latency: capture visible 1 cycle after the btn rising edge; first step 1..TICK_DIV
//   cycles later, then one step every TICK_DIV cycles.
// Backpressure: none; presses during a walk are dropped, not queued.
// Ports:
//   clk   - system clock, rising edge
//   clr   - synchronous active-low reset
//   in    - 8-bit target position code
//   btn   - load request (level; rising edge acts)
//   out   - registered one-hot position (W_OUT bits)
//   pos   - binary position currently shown on out
//   busy  - walk in progress
//   err   - last captured code was out of range (>= W_OUT)
module deshifr_walk #(
  parameter int TICK_DIV = 100000000,
  parameter int W_OUT    = 16,
  localparam int PW      = (W_OUT > 1) ? $clog2(W_OUT) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             btn,
  output logic [W_OUT-1:0] out,
  output logic [PW-1:0]    pos,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [31:0]      TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [W_OUT-1:0] ONE_HOT0  = W_OUT'(1);

  state_t           r_state;
  logic [31:0]      r_cnt;
  logic             r_btn_q;
  logic [PW-1:0]    r_pos;
  logic [PW-1:0]    r_tgt;
  logic             r_busy;
  logic             r_err;
  logic [W_OUT-1:0] r_out;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_pos_nxt;
  logic [PW-1:0]    w_tgt_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;
  logic [W_OUT-1:0] w_out_nxt;
  logic             w_rise;
  logic             w_tick;
  logic [8:0]       w_in9;
  logic             w_bad;
  logic             w_same;

  // Range and equality checks are done at 9 bits so codes >= W_OUT never alias.
  assign w_rise = btn & ~r_btn_q;
  assign w_tick = (r_cnt == TICK_LAST);
  assign w_in9  = {1'b0, in};
  assign w_bad  = (w_in9 >= 9'(W_OUT));
  assign w_same = (w_in9 == 9'(r_pos));

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_tgt_nxt   = r_tgt;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE, S_ERR: begin
        // A tick coinciding with the capture edge does not step; the walk
        // starts on the next tick.
        if (w_rise) begin
          if (w_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end else if (w_same) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_tgt_nxt   = in[PW-1:0];
            w_err_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (w_tick) begin
          if (r_tgt > r_pos) begin
            w_pos_nxt = r_pos + PW'(1);
          end else if (r_tgt < r_pos) begin
            w_pos_nxt = r_pos - PW'(1);
          end
          // busy drops on the same edge that lands the final position.
          if (w_pos_nxt == r_tgt) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
    w_out_nxt = ONE_HOT0 << w_pos_nxt;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_btn_q <= 1'b1;  // a btn held high through reset yields no edge
      r_pos   <= '0;
      r_tgt   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= ONE_HOT0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_tick ? 32'd0 : r_cnt + 32'd1;
      r_btn_q <= btn;
      r_pos   <= w_pos_nxt;
      r_tgt   <= w_tgt_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign out  = r_out;
  assign pos  = r_pos;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_deshifr_walk.sv
// Directed bench for deshifr_walk with TICK_DIV=4, W_OUT=16.
module tb_deshifr_walk;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        btn = 1'b1;
  logic [7:0]  din = 8'd0;
  logic [15:0] out;
  logic [3:0]  pos;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  deshifr_walk #(.TICK_DIV(4), .W_OUT(16)) dut (
    .clk (clk),
    .clr (clr),
    .in  (din),
    .btn (btn),
    .out (out),
    .pos (pos),
    .busy(busy),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle btn pulse; returns #1 after the capture edge.
  task automatic press(input logic [7:0] code);
    din = code;
    btn = 1'b1;
    cyc();
    btn = 1'b0;
  endtask

  task automatic wait_change(input logic [15:0] prev, input int limit, output int n);
    n = 0;
    while (out === prev && n < limit) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; btn = 1'b1; din = 8'd0;
    cyc(); cyc();
    n_cmp++; if (out !== 16'h0001) begin n_bad++; $display("FAIL reset_out: got %h want 0001", out); end
    n_cmp++; if (pos !== 4'd0)     begin n_bad++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    clr = 1'b1; din = 8'd5;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (busy !== 1'b0 || pos !== 4'd0) begin
        n_bad++; $display("FAIL held_btn_no_capture: busy=%b pos=%0d want busy=0 pos=0", busy, pos);
      end
    end
    btn = 1'b0;
    cyc();
  endtask

  task automatic test_forward();
    int          n;
    logic [15:0] prev;
    logic [15:0] exp;
    press(8'd5);
    n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL fwd_busy_rise: got %b want 1", busy); end
    n_cmp++; if (out !== 16'h0001) begin n_bad++; $display("FAIL fwd_capture_out: got %h want 0001", out); end
    for (int k = 1; k <= 5; k++) begin
      prev = out;
      wait_change(prev, 8, n);
      exp = 16'(1) << k;
      n_cmp++;
      if ((k == 1) ? (n < 1 || n > 4) : (n != 4)) begin
        n_bad++; $display("FAIL fwd_spacing step %0d: got %0d cycles want %s", k, n, (k == 1) ? "1..4" : "4");
      end
      n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL fwd_out step %0d: got %h want %h", k, out, exp); end
      n_cmp++; if (pos !== 4'(k)) begin n_bad++; $display("FAIL fwd_pos step %0d: got %0d want %0d", k, pos, k); end
      n_cmp++;
      if (busy !== (k < 5)) begin
        n_bad++; $display("FAIL fwd_busy step %0d: got %b want %b", k, busy, (k < 5));
      end
    end
  endtask

  task automatic test_reverse();
    int          n;
    logic [15:0] prev;
    logic [15:0] exp;
    cyc();
    press(8'd2);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rev_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      prev = out;
      wait_change(prev, 8, n);
      exp = 16'h0010 >> i;
      n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL rev_out step %0d: got %h want %h", i, out, exp); end
      n_cmp++; if (pos !== 4'(4 - i)) begin n_bad++; $display("FAIL rev_pos step %0d: got %0d want %0d", i, pos, 4 - i); end
      if (i == 0) press(8'd9);  // ignored while walking
    end
    for (int i = 0; i < 10; i++) cyc();
    n_cmp++; if (out !== 16'h0004) begin n_bad++; $display("FAIL rev_final_out: got %h want 0004", out); end
    n_cmp++; if (pos !== 4'd2)     begin n_bad++; $display("FAIL rev_final_pos: got %0d want 2", pos); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rev_final_busy: got %b want 0", busy); end
  endtask

  task automatic test_error();
    int n;
    press(8'd16);
    n_cmp++; if (err !== 1'b1)     begin n_bad++; $display("FAIL err_set16: got %b want 1", err); end
    n_cmp++; if (out !== 16'h0004) begin n_bad++; $display("FAIL err_out16: got %h want 0004", out); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL err_busy16: got %b want 0", busy); end
    cyc();
    press(8'd20);
    n_cmp++; if (err !== 1'b1)     begin n_bad++; $display("FAIL err_hold20: got %b want 1", err); end
    n_cmp++; if (pos !== 4'd2)     begin n_bad++; $display("FAIL err_pos20: got %0d want 2", pos); end
    cyc();
    press(8'd3);
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL err_recover_busy: got %b want 1", busy); end
    wait_change(16'h0004, 8, n);
    n_cmp++; if (out !== 16'h0008) begin n_bad++; $display("FAIL err_walk_out: got %h want 0008", out); end
    n_cmp++; if (pos !== 4'd3)     begin n_bad++; $display("FAIL err_walk_pos: got %0d want 3", pos); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL err_walk_busy: got %b want 0", busy); end
  endtask

  task automatic test_same();
    cyc();
    press(8'd3);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || err !== 1'b0 || out !== 16'h0008) begin
        n_bad++; $display("FAIL same_pos: busy=%b err=%b out=%h want 0 0 0008", busy, err, out);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    int          n;
    logic [15:0] prev;
    logic [15:0] exp;
    press(8'd15);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      prev = out;
      wait_change(prev, 8, n);
      exp = 16'h0010 << i;
      n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL mid_out step %0d: got %h want %h", i, out, exp); end
    end
    clr = 1'b0;
    cyc();
    n_cmp++; if (out !== 16'h0001) begin n_bad++; $display("FAIL mid_reset_out: got %h want 0001", out); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_cmp++; if (pos !== 4'd0)     begin n_bad++; $display("FAIL mid_reset_pos: got %0d want 0", pos); end
    clr = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    n_cmp++;
    if (out !== 16'h0001 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_abandoned: out=%h busy=%b want 0001 0", out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_error();
    test_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
